// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the data memory (slave).
// Handshake: dm_req is raised with dm_we/dm_addr/dm_wdata stable and held until
// the memory answers with a single-cycle dm_ack; dm_rdata is valid in that ack cycle.
interface mem_access_unit_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns load/store requests from the core into
// req/ack transactions, stalls the core until they finish, serves repeated
// loads from a single-entry last-access buffer and flags timed-out accesses.
module mem_access_unit #(
  parameter int AW      = 7,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] st_data,
  output logic [DW-1:0] ld_data,
  output logic          stall,
  output logic          err,
  output logic [1:0]    fsm_state,
  mem_access_unit_if.master dm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last REQ cycle that may still wait for an ack before the access is aborted.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [7:0]    cnt;
  logic          req_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] ld_q;
  logic          err_q;

  logic access, hit, start, done_ok, done_to;

  // A simultaneous read+write counts as a write, so it can never hit.
  assign access = mem_read | mem_write;
  assign hit    = mem_read & ~mem_write & buf_valid & (mem_addr == buf_addr);

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign err         = err_q;
  assign fsm_state   = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, stall and load-data selection.
  always_comb begin
    state_n = state;
    stall   = 1'b0;
    ld_data = '0;
    start   = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (hit) begin
            ld_data = buf_data;
          end else begin
            stall   = 1'b1;
            start   = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // An ack in the last allowed cycle still completes the access.
        if (dm.dm_ack) begin
          done_ok = 1'b1;
          state_n = DONE;
        end else if (cnt == TO_LAST) begin
          done_to = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        ld_data = ld_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!rst_n) stall = 1'b0;
  end

  // Request registers, timeout counter, result capture and last-access buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      ld_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= done_to;
      if (state == REQ && !done_ok && !done_to) cnt <= cnt + 8'd1;
      else                                      cnt <= '0;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= mem_write;
        addr_q  <= mem_addr;
        wdata_q <= st_data;
      end
      if (done_ok) begin
        req_q     <= 1'b0;
        ld_q      <= we_q ? '0 : dm.dm_rdata;
        buf_valid <= 1'b1;
        buf_addr  <= addr_q;
        buf_data  <= we_q ? wdata_q : dm.dm_rdata;
      end
      if (done_to) begin
        req_q     <= 1'b0;
        ld_q      <= '0;
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomised bench for mem_access_unit with a scripted memory
// responder and a small last-access-buffer model.
module tb_mem_access_unit;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] st_data;
  logic [DW-1:0] ld_data;
  logic          stall, err;
  logic [1:0]    fsm_state;

  mem_access_unit_if #(.AW(AW), .DW(DW)) dm_bus ();

  mem_access_unit #(.AW(AW), .DW(DW), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .st_data   (st_data),
    .ld_data   (ld_data),
    .stall     (stall),
    .err       (err),
    .fsm_state (fsm_state),
    .dm        (dm_bus.master)
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  // Bench-side model of the last-access buffer.
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one instruction from a negedge; the memory acks in REQ cycle ack_at
  // (0 = never). Returns at the negedge following the completion cycle.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int ack_at, input logic [DW-1:0] rdata,
                           input logic [DW-1:0] exp_ld, input int exp_stall,
                           input logic exp_err);
    int stall_cnt = 0;
    int req_cnt   = 0;
    bit done      = 0;
    logic [DW-1:0] exp_v;
    exp_q.push_back(exp_ld);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    st_data   = wdata;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (!stall) begin
        done = 1;
        break;
      end
      stall_cnt++;
      if (dm_bus.dm_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({tag, "_we"},   {31'd0, dm_bus.dm_we}, {31'd0, wr});
          check({tag, "_addr"}, {25'd0, dm_bus.dm_addr}, {25'd0, addr});
          if (wr) check({tag, "_wdata"}, dm_bus.dm_wdata, wdata);
        end
        if (req_cnt == ack_at) begin
          dm_bus.dm_ack   = 1'b1;
          dm_bus.dm_rdata = rdata;
        end
      end
      @(negedge clk);
      dm_bus.dm_ack   = 1'b0;
      dm_bus.dm_rdata = $urandom;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_bound observed=stalled expected=completion", tag);
    end
    exp_v = exp_q.pop_front();
    check({tag, "_ld"},    ld_data, exp_v);
    check({tag, "_stall"}, stall_cnt, exp_stall);
    check({tag, "_req"},   req_cnt, (exp_stall > 0) ? exp_stall - 1 : 0);
    check({tag, "_err"},   {31'd0, err}, {31'd0, exp_err});
    check({tag, "_dmreq"}, {31'd0, dm_bus.dm_req}, 32'd0);
    if (exp_stall > 0) begin
      if (exp_err) m_valid = 1'b0;
      else begin
        m_valid = 1'b1;
        m_addr  = addr;
        m_data  = wr ? wdata : rdata;
      end
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    int            r_ack;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    st_data   = '0;
    dm_bus.dm_ack   = 1'b0;
    dm_bus.dm_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_dmreq", {31'd0, dm_bus.dm_req}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_ld",    ld_data, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access("rd_miss05", 1, 0, 7'h05, 32'h0, 1, 32'hCAFEBABE, 32'hCAFEBABE, 2, 0);
    do_access("rd_hit05",  1, 0, 7'h05, 32'h0, 0, 32'h0,        32'hCAFEBABE, 0, 0);
    do_access("wr_0a",     0, 1, 7'h0A, 32'h12345678, 3, 32'hDEADDEAD, 32'h0, 4, 0);
    do_access("rd_hit0a",  1, 0, 7'h0A, 32'h0, 0, 32'h0, 32'h12345678, 0, 0);
    do_access("rd_to7f",   1, 0, 7'h7F, 32'h0, 0, 32'h0, 32'h0, 65, 1);

    // A late ack after the abort must be ignored.
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    check("late_ack_state", {30'd0, fsm_state}, 32'd0);
    check("late_ack_dmreq", {31'd0, dm_bus.dm_req}, 32'd0);

    do_access("rd_re7f", 1, 0, 7'h7F, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 2, 0);

    // Reset in the middle of a request for 0x05.
    mem_read = 1'b1;
    mem_addr = 7'h05;
    @(negedge clk);
    check("mid_req_dmreq", {31'd0, dm_bus.dm_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_dmreq", {31'd0, dm_bus.dm_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_state", {30'd0, fsm_state}, 32'd0);
    rst_n    = 1'b1;
    mem_read = 1'b0;
    m_valid  = 1'b0;
    @(negedge clk);
    do_access("rd_after_rst", 1, 0, 7'h05, 32'h0, 2, 32'h11223344, 32'h11223344, 3, 0);

    do_access("rdwr_03",  1, 1, 7'h03, 32'hA5A5A5A5, 1, 32'h77777777, 32'h0, 2, 0);
    do_access("rd_hit03", 1, 0, 7'h03, 32'h0, 0, 32'h0, 32'hA5A5A5A5, 0, 0);

    // Random traffic over a small address window so hits and misses mix.
    for (int i = 0; i < 12; i++) begin
      r_wr   = ($urandom_range(0, 3) == 0);
      r_addr = 7'(32'h20 + $urandom_range(0, 2));
      r_data = $urandom;
      r_ack  = $urandom_range(1, 4);
      if (r_wr)
        do_access("rnd_wr", $urandom_range(0, 1) == 1, 1, r_addr, r_data, r_ack, $urandom, 32'h0, r_ack + 1, 0);
      else if (m_valid && m_addr == r_addr)
        do_access("rnd_hit", 1, 0, r_addr, 32'h0, 0, 32'h0, m_data, 0, 0);
      else
        do_access("rnd_miss", 1, 0, r_addr, 32'h0, r_ack, r_data, r_data, r_ack + 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
